// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its data-memory bus.
package mem_access_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
  localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  // Request fields held on the bus while an access is outstanding
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [BE_W-1:0] dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication, byte enables, load extract/extend and
// the natural-alignment check for the MEM stage.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]      i_size,
  input  logic [1:0]      i_addr_lo,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [BE_W-1:0] o_be,
  output logic [XLEN-1:0] o_rd,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wdata    = i_wd;
    o_be       = BE_NONE;
    o_rd       = i_rdata;
    o_misalign = 1'b0;
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    case (i_size)
      SZ_BYTE: begin
        o_wdata = {4{i_wd[7:0]}};
        o_be    = BE_BYTE0 << i_addr_lo;
        w_byte  = 8'(i_rdata >> {i_addr_lo, 3'b000});
        o_rd    = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
      end
      SZ_HALF: begin
        o_wdata    = {2{i_wd[15:0]}};
        o_be       = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_rd       = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
        o_misalign = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_be       = BE_WORD;
        o_misalign = |i_addr_lo;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, freezes the
// upstream pipeline until ack (or timeout), and presents the write-back bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             MemRead_in,
  input  logic             MemWrite_in,
  input  logic [1:0]       MemSize_in,
  input  logic             MemSigned_in,
  input  logic [XLEN-1:0]  ALU_in,
  input  logic [XLEN-1:0]  WD_in,
  input  logic [REG_W-1:0] WN_in,
  input  logic             RegWrite_in,
  input  logic             MemtoReg_in,
  mem_access_stage_if.master dmem,
  output logic             stall_out,
  output logic             wb_en_out,
  output logic             RegWrite_out,
  output logic             MemtoReg_out,
  output logic [XLEN-1:0]  RD_out,
  output logic [XLEN-1:0]  ALU_out,
  output logic [REG_W-1:0] WN_out,
  output logic             misalign_out,
  output logic             bus_err_out
);

  state_e          r_state, w_state_nxt;
  logic            r_req, w_req_nxt;
  dmem_req_t       r_pl, w_pl_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_rdata, w_rdata_nxt;
  logic            r_fault, w_fault_nxt;
  logic            r_bus_err, w_bus_err_nxt;

  logic [XLEN-1:0] w_wdata;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_rd_fmt;
  logic            w_misalign;
  logic            w_mem_op;
  logic            w_timeout;

  mem_lane_align u_lane (
    .i_size     (MemSize_in),
    .i_addr_lo  (ALU_in[1:0]),
    .i_signed   (MemSigned_in),
    .i_wd       (WD_in),
    .i_rdata    (r_rdata),
    .o_wdata    (w_wdata),
    .o_be       (w_be),
    .o_rd       (w_rd_fmt),
    .o_misalign (w_misalign)
  );

  assign w_mem_op  = valid_in & (MemRead_in | MemWrite_in);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_pl      <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_fault   <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_pl      <= w_pl_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdata   <= w_rdata_nxt;
      r_fault   <= w_fault_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_pl_nxt      = r_pl;
    w_cnt_nxt     = r_cnt;
    w_rdata_nxt   = r_rdata;
    w_fault_nxt   = r_fault;
    w_bus_err_nxt = 1'b0;
    stall_out     = 1'b0;
    wb_en_out     = 1'b1;
    misalign_out  = 1'b0;
    RegWrite_out  = RegWrite_in;
    RD_out        = r_rdata;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misalign) begin
            misalign_out = 1'b1;
            RegWrite_out = 1'b0;
          end else begin
            stall_out   = 1'b1;
            wb_en_out   = 1'b0;
            w_state_nxt = BUSY;
            w_req_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_pl_nxt    = '{we: MemWrite_in, addr: {ALU_in[31:2], 2'b00},
                            be: w_be, wdata: w_wdata};
          end
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        wb_en_out = 1'b0;
        w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
        if (dmem.dmem_ack) begin
          w_rdata_nxt = dmem.dmem_rdata;
          w_req_nxt   = 1'b0;
          w_pl_nxt.we = 1'b0;
          w_pl_nxt.be = BE_NONE;
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_req_nxt     = 1'b0;
          w_pl_nxt.we   = 1'b0;
          w_pl_nxt.be   = BE_NONE;
          w_fault_nxt   = 1'b1;
          w_bus_err_nxt = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        // EX/MEM is still frozen, so the inputs describe the completing op
        RD_out       = w_rd_fmt;
        RegWrite_out = RegWrite_in & ~r_fault;
        w_cnt_nxt    = '0;
        w_fault_nxt  = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_pl.we;
  assign dmem.dmem_addr  = r_pl.addr;
  assign dmem.dmem_be    = r_pl.be;
  assign dmem.dmem_wdata = r_pl.wdata;

  assign ALU_out      = ALU_in;
  assign WN_out       = WN_in;
  assign MemtoReg_out = MemtoReg_in;
  assign bus_err_out  = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a byte-lane model.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in, mem_rd, mem_wr, mem_signed, regwrite_in, memtoreg_in;
  logic [1:0]  mem_size;
  logic [31:0] alu_in, wd_in;
  logic [4:0]  wn_in;

  logic        stall0, wben0, rw0, m2r0, mis0, berr0;
  logic [31:0] rd0, alu0;
  logic [4:0]  wn0;
  logic        stall1, wben1, rw1, m2r1, mis1, berr1;
  logic [31:0] rd1, alu1;
  logic [4:0]  wn1;

  int checks = 0;
  int failures = 0;

  mem_access_stage_if bus0 ();
  mem_access_stage_if bus1 ();

  mem_access_stage u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .MemRead_in(mem_rd),
    .MemWrite_in(mem_wr), .MemSize_in(mem_size), .MemSigned_in(mem_signed),
    .ALU_in(alu_in), .WD_in(wd_in), .WN_in(wn_in), .RegWrite_in(regwrite_in),
    .MemtoReg_in(memtoreg_in), .dmem(bus0), .stall_out(stall0), .wb_en_out(wben0),
    .RegWrite_out(rw0), .MemtoReg_out(m2r0), .RD_out(rd0), .ALU_out(alu0),
    .WN_out(wn0), .misalign_out(mis0), .bus_err_out(berr0)
  );

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .MemRead_in(mem_rd),
    .MemWrite_in(mem_wr), .MemSize_in(mem_size), .MemSigned_in(mem_signed),
    .ALU_in(alu_in), .WD_in(wd_in), .WN_in(wn_in), .RegWrite_in(regwrite_in),
    .MemtoReg_in(memtoreg_in), .dmem(bus1), .stall_out(stall1), .wb_en_out(wben1),
    .RegWrite_out(rw1), .MemtoReg_out(m2r1), .RD_out(rd1), .ALU_out(alu1),
    .WN_out(wn1), .misalign_out(mis1), .bus_err_out(berr1)
  );

  // Reference model: an access covers 2**size bytes starting at byte offset addr%4
  function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = 1 << sz;
    return (sz == 2'b11) || ((a % n) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    logic [3:0] be;
    n = 1 << sz;
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    int nb;
    logic [31:0] v, mask;
    nb = 8 * (1 << sz);
    v = rd >> (8 * (a % 4));
    if (nb < 32) begin
      mask = (32'h1 << nb) - 32'h1;
      v = v & mask;
      if (sgn && v[nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic drive_idle();
    valid_in = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'b00;
    mem_signed = 1'b0; alu_in = 32'h0; wd_in = 32'h0; wn_in = 5'd0;
    regwrite_in = 1'b0; memtoreg_in = 1'b0;
  endtask

  // One memory op on u_dut; starts and ends just after a rising edge with the stage idle
  task automatic do_mem_op(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay, input logic rw,
                           input string tag);
    logic mis;
    mis = m_misalign(sz, a);
    valid_in = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz; mem_signed = sgn;
    alu_in = a; wd_in = wd; wn_in = 5'($urandom_range(0, 31)); regwrite_in = rw;
    memtoreg_in = rd;
    bus0.dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall0, wben0, bus0.dmem_req, mis0} !== {~mis, mis, 1'b0, mis}) begin
      failures++;
      $display("FAIL %s idle stall/wben/req/mis got=%b exp=%b", tag,
               {stall0, wben0, bus0.dmem_req, mis0}, {~mis, mis, 1'b0, mis});
    end
    checks++;
    if (rw0 !== (rw & ~mis)) begin
      failures++;
      $display("FAIL %s idle regwrite got=%b exp=%b", tag, rw0, rw & ~mis);
    end
    if (mis) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      checks++;
      if ({bus0.dmem_req, stall0, mis0} !== 3'b000) begin
        failures++;
        $display("FAIL %s after-misalign req/stall/mis got=%b exp=000", tag,
                 {bus0.dmem_req, stall0, mis0});
      end
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      for (int k = 0; k <= delay; k++) begin
        @(negedge clk);
        checks++;
        if ({bus0.dmem_req, bus0.dmem_we, stall0, wben0} !== {1'b1, wr, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL %s busy%0d req/we/stall/wben got=%b exp=%b", tag, k,
                   {bus0.dmem_req, bus0.dmem_we, stall0, wben0}, {1'b1, wr, 1'b1, 1'b0});
        end
        checks++;
        if ({bus0.dmem_addr, bus0.dmem_be} !== {a & 32'hFFFF_FFFC, m_be(sz, a)}) begin
          failures++;
          $display("FAIL %s busy%0d addr/be got=%h/%b exp=%h/%b", tag, k, bus0.dmem_addr,
                   bus0.dmem_be, a & 32'hFFFF_FFFC, m_be(sz, a));
        end
        if (wr) begin
          checks++;
          if (bus0.dmem_wdata !== m_wdata(sz, wd)) begin
            failures++;
            $display("FAIL %s busy%0d wdata got=%h exp=%h", tag, k, bus0.dmem_wdata,
                     m_wdata(sz, wd));
          end
        end
        if (k == delay) begin
          bus0.dmem_ack = 1'b1;
          bus0.dmem_rdata = rdata;
        end
        @(posedge clk); #1;
      end
      bus0.dmem_ack = 1'b0;
      bus0.dmem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({bus0.dmem_req, stall0, wben0, berr0, rw0} !== {4'b0010, rw}) begin
        failures++;
        $display("FAIL %s done req/stall/wben/berr/rw got=%b exp=%b", tag,
                 {bus0.dmem_req, stall0, wben0, berr0, rw0}, {4'b0010, rw});
      end
      if (rd && !wr) begin
        checks++;
        if (rd0 !== m_load(sz, sgn, a, rdata)) begin
          failures++;
          $display("FAIL %s done rd got=%h exp=%h", tag, rd0, m_load(sz, sgn, a, rdata));
        end
      end
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus0.dmem_ack = 1'b0; bus0.dmem_rdata = 32'h0;
    bus1.dmem_ack = 1'b0; bus1.dmem_rdata = 32'h0;
    #3;
    checks++;
    if ({bus0.dmem_req, bus0.dmem_we, bus0.dmem_be, stall0, wben0, mis0, berr0} !== 9'b000000100) begin
      failures++;
      $display("FAIL reset req/we/be/stall/wben/mis/berr got=%b exp=000000100",
               {bus0.dmem_req, bus0.dmem_we, bus0.dmem_be, stall0, wben0, mis0, berr0});
    end
    checks++;
    if (rd0 !== 32'h0) begin
      failures++;
      $display("FAIL reset rd got=%h exp=00000000", rd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    valid_in = 1'b1; alu_in = 32'h1234; wn_in = 5'd5; regwrite_in = 1'b1; memtoreg_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({stall0, wben0, bus0.dmem_req, rw0, m2r0} !== 5'b01010) begin
        failures++;
        $display("FAIL alu_op%0d stall/wben/req/rw/m2r got=%b exp=01010", c,
                 {stall0, wben0, bus0.dmem_req, rw0, m2r0});
      end
      checks++;
      if ({alu0, wn0} !== {32'h1234, 5'd5}) begin
        failures++;
        $display("FAIL alu_op%0d alu/wn got=%h/%0d exp=1234/5", c, alu0, wn0);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_loads();
    do_mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, "lw");
    do_mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1'b1, "lb");
    do_mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1'b1, "lbu");
    do_mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h9ABC1234, 2, 1'b1, "lh");
  endtask

  task automatic test_store_hold();
    do_mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 5, 1'b0, "sh");
    do_mem_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h301, 32'h11223344, 32'h0, 1, 1'b0, "ld_st");
  endtask

  task automatic test_misalign();
    do_mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 0, 1'b1, "lw_mis");
    do_mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'hABCD, 32'h0, 0, 1'b1, "sh_mis");
    do_mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 32'h0, 0, 1'b1, "rsvd");
  endtask

  task automatic test_random();
    logic [1:0] ty, sz;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      ty = 2'($urandom_range(1, 3));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      do_mem_op(ty[0], ty[1], sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                $urandom_range(0, 4), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_timeout();
    valid_in = 1'b1; mem_rd = 1'b1; mem_size = 2'b10; alu_in = 32'h40; regwrite_in = 1'b1;
    bus1.dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall1, bus1.dmem_req} !== 2'b10) begin
      failures++;
      $display("FAIL timeout idle stall/req got=%b exp=10", {stall1, bus1.dmem_req});
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus1.dmem_req, berr1, stall1} !== 3'b101) begin
        failures++;
        $display("FAIL timeout busy%0d req/berr/stall got=%b exp=101", k,
                 {bus1.dmem_req, berr1, stall1});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus1.dmem_req, berr1, stall1, wben1, rw1} !== 5'b01010) begin
      failures++;
      $display("FAIL timeout done req/berr/stall/wben/rw got=%b exp=01010",
               {bus1.dmem_req, berr1, stall1, wben1, rw1});
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++;
    if ({berr1, stall1, bus1.dmem_req} !== 3'b000) begin
      failures++;
      $display("FAIL timeout after berr/stall/req got=%b exp=000", {berr1, stall1, bus1.dmem_req});
    end
  endtask

  // u_dut is left waiting on an ack that never came; reset it mid-access
  task automatic test_reset_mid_busy();
    checks++;
    if ({bus0.dmem_req, stall0} !== 2'b11) begin
      failures++;
      $display("FAIL midrst before req/stall got=%b exp=11", {bus0.dmem_req, stall0});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.dmem_req, stall0, wben0} !== 3'b001) begin
      failures++;
      $display("FAIL midrst async req/stall/wben got=%b exp=001", {bus0.dmem_req, stall0, wben0});
    end
    bus0.dmem_ack = 1'b1;
    bus0.dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus0.dmem_req, stall0, wben0, rd0} !== {3'b001, 32'h0}) begin
      failures++;
      $display("FAIL midrst after req/stall/wben/rd got=%b/%h exp=001/00000000",
               {bus0.dmem_req, stall0, wben0}, rd0);
    end
    @(posedge clk); #1;
    bus0.dmem_ack = 1'b0;
    do_mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 0, 1'b1, "lw_post");
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_loads();
    test_store_hold();
    test_misalign();
    test_random();
    test_reset();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
